// File: rtl/imem_uart_loader.sv
// UART (8N1) program loader: assembles little-endian words and writes them to instruction memory,
// holding the core in reset during a load. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_uart_loader #(
   parameter int         CLKS_PER_BIT = 434,
   parameter int         MEM_WORDS    = 256,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        uart_rx,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_rstn,
   output logic        load_busy,
   output logic        load_done,
   output logic        load_err
);
   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [16:0]   MAX_WORDS = 17'(MEM_WORDS);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {L_IDLE, L_LEN0, L_LEN1, L_DATA, L_CHK, L_DONE, L_ERR} ldState_t;
   localparam ldState_t L_TAIL = L_CHK;
`else
   typedef enum logic [2:0] {L_IDLE, L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR} ldState_t;
   localparam ldState_t L_TAIL = L_DONE;
`endif

   logic [1:0]    r_rxSync;
   logic          r_rxPrev;
   rxState_t      r_rxState, w_rxStateNext;
   logic [CW-1:0] r_rxCnt;
   logic [2:0]    r_rxBit;
   logic [7:0]    r_rxShift;
   logic          w_rxIn;
   logic          w_rxValid;
   logic          w_rxFerr;
   logic [7:0]    w_rxByte;

   ldState_t      r_state, w_stateNext;
   logic [7:0]    r_lenLo;
   logic [15:0]   r_len;
   logic [15:0]   r_wordIdx;
   logic [15:0]   w_lenFull;
   logic [1:0]    r_byteIdx;
   logic [23:0]   r_wordBuf;
   logic          w_syncAccept;
   logic          w_wordWrite;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    r_xor;
`endif

   logic          r_imemWe;
   logic [31:0]   r_imemAddr;
   logic [31:0]   r_imemWdata;
   logic          r_coreRstn;
   logic          r_loadBusy;
   logic          r_loadDone;
   logic          r_loadErr;

   assign w_rxIn     = r_rxSync[1];
   assign w_rxByte   = r_rxShift;
   assign w_lenFull  = {w_rxByte, r_lenLo};

   assign imem_we    = r_imemWe;
   assign imem_addr  = r_imemAddr;
   assign imem_wdata = r_imemWdata;
   assign core_rstn  = r_coreRstn;
   assign load_busy  = r_loadBusy;
   assign load_done  = r_loadDone;
   assign load_err   = r_loadErr;

   // Synchronizer flops reset to the idle-high line level so reset release is not seen as a start edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rxSync <= 2'b11;
         r_rxPrev <= 1'b1;
      end else begin
         r_rxSync <= {r_rxSync[0], uart_rx};
         r_rxPrev <= w_rxIn;
      end
   end

   always_comb begin
      w_rxStateNext = r_rxState;
      w_rxValid     = 1'b0;
      w_rxFerr      = 1'b0;
      case (r_rxState)
         RX_IDLE:  if (r_rxPrev && !w_rxIn) w_rxStateNext = RX_START;
         RX_START: if (r_rxCnt == HALF_LAST) w_rxStateNext = w_rxIn ? RX_IDLE : RX_DATA;
         RX_DATA:  if (r_rxCnt == BIT_LAST && r_rxBit == 3'd7) w_rxStateNext = RX_STOP;
         RX_STOP: begin
            if (r_rxCnt == BIT_LAST) begin
               w_rxStateNext = RX_IDLE;
               w_rxValid     = w_rxIn;
               w_rxFerr      = !w_rxIn;
            end
         end
         default:  w_rxStateNext = RX_IDLE;
      endcase
   end

   // The bit timer restarts on every state change, so after the half-bit start check it lands on bit centres.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rxState <= RX_IDLE;
         r_rxCnt   <= '0;
         r_rxBit   <= '0;
         r_rxShift <= '0;
      end else begin
         r_rxState <= w_rxStateNext;
         if (r_rxState == RX_IDLE || w_rxStateNext != r_rxState || r_rxCnt == BIT_LAST)
            r_rxCnt <= '0;
         else
            r_rxCnt <= r_rxCnt + 1'b1;
         if (r_rxState == RX_DATA && r_rxCnt == BIT_LAST) begin
            r_rxShift <= {w_rxIn, r_rxShift[7:1]};
            r_rxBit   <= r_rxBit + 1'b1;
         end
      end
   end

   always_comb begin
      w_stateNext  = r_state;
      w_syncAccept = 1'b0;
      w_wordWrite  = 1'b0;
      case (r_state)
         L_IDLE: begin
            if (w_rxValid && w_rxByte == SYNC_BYTE) begin
               w_stateNext  = L_LEN0;
               w_syncAccept = 1'b1;
            end
         end
         L_LEN0: begin
            if (w_rxFerr)       w_stateNext = L_ERR;
            else if (w_rxValid) w_stateNext = L_LEN1;
         end
         L_LEN1: begin
            if (w_rxFerr) w_stateNext = L_ERR;
            else if (w_rxValid) begin
               if ({1'b0, w_lenFull} > MAX_WORDS) w_stateNext = L_ERR;
               else if (w_lenFull == 16'd0)       w_stateNext = L_TAIL;
               else                               w_stateNext = L_DATA;
            end
         end
         L_DATA: begin
            if (w_rxFerr) w_stateNext = L_ERR;
            else if (w_rxValid && r_byteIdx == 2'd3) begin
               w_wordWrite = 1'b1;
               if (r_wordIdx == r_len - 16'd1) w_stateNext = L_TAIL;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         L_CHK: begin
            if (w_rxFerr)       w_stateNext = L_ERR;
            else if (w_rxValid) w_stateNext = (w_rxByte == r_xor) ? L_DONE : L_ERR;
         end
`endif
         L_DONE:  w_stateNext = L_IDLE;
         L_ERR:   w_stateNext = L_IDLE;
         default: w_stateNext = L_IDLE;
      endcase
   end

   // core_rstn is released whenever the loader is idle without a pending error, including right after reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= L_IDLE;
         r_lenLo     <= '0;
         r_len       <= '0;
         r_wordIdx   <= '0;
         r_byteIdx   <= '0;
         r_wordBuf   <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_xor       <= '0;
`endif
         r_imemWe    <= 1'b0;
         r_imemAddr  <= '0;
         r_imemWdata <= '0;
         r_coreRstn  <= 1'b0;
         r_loadBusy  <= 1'b0;
         r_loadDone  <= 1'b0;
         r_loadErr   <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_imemWe <= w_wordWrite;
         if (w_syncAccept) begin
            r_byteIdx  <= '0;
            r_wordIdx  <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
            r_loadBusy <= 1'b1;
            r_loadDone <= 1'b0;
            r_loadErr  <= 1'b0;
            r_coreRstn <= 1'b0;
         end
         if (r_state == L_LEN0 && w_rxValid) r_lenLo <= w_rxByte;
         if (r_state == L_LEN1 && w_rxValid) r_len   <= w_lenFull;
         if (r_state == L_DATA && w_rxValid) begin
`ifdef LOADER_CHECKSUM_EN
            r_xor     <= r_xor ^ w_rxByte;
`endif
            r_byteIdx <= r_byteIdx + 1'b1;
            r_wordBuf <= {w_rxByte, r_wordBuf[23:8]};
         end
         if (w_wordWrite) begin
            r_imemAddr  <= {14'd0, r_wordIdx, 2'b00};
            r_imemWdata <= {w_rxByte, r_wordBuf};
            r_wordIdx   <= r_wordIdx + 16'd1;
         end
         if (r_state == L_DONE) begin
            r_loadDone <= 1'b1;
            r_loadBusy <= 1'b0;
            r_coreRstn <= 1'b1;
         end
         if (r_state == L_ERR) begin
            r_loadErr  <= 1'b1;
            r_loadBusy <= 1'b0;
         end
         if (r_state == L_IDLE && !r_loadErr && !w_syncAccept) r_coreRstn <= 1'b1;
      end
   end
endmodule
